bcd_scan_display: RTL

- Downstream consumer of the mod-10 digit counters.
- Takes a bus of packed BCD digits, one 4-bit digit per counter stage, and snapshots it on a load strobe.
- Time-multiplexes the digits onto one shared 7-segment bus with per-digit anode enables.
- Fixed scan rate, guard blanking at each digit switch to prevent ghosting, invalid-code blanking.

---
 rtl/bcd_scan_display_if.sv | 22 ++
 rtl/bcd_scan_display.sv | 105 ++++++++++
 2 files changed

// File: rtl/bcd_scan_display_if.sv
// Bus between the BCD scan display and its driver: digit snapshot inputs plus
// the multiplexed 7-segment/anode outputs.
interface bcd_scan_display_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  load;
    logic [4*DIGITS-1:0]   bcd_in;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     an;
    logic                  slot_start;

    modport master (
        output en, load, bcd_in,
        input  seg, an, slot_start
    );

    modport slave (
        input  en, load, bcd_in,
        output seg, an, slot_start
    );
endinterface

// File: rtl/bcd_scan_display.sv
// Time-multiplexed BCD 7-segment driver with per-slot guard blanking.
// Define BCD_SCAN_LZB_EN to add leading-zero blanking.
module bcd_scan_display #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int GUARD    = 2
) (
    input  logic               clk,
    input  logic               rst,
    bcd_scan_display_if.slave  bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] GUARD_P  = PW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [4*DIGITS-1:0] snap_q, snap_d;
    logic [PW-1:0]       pre_q, pre_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                slot_start_q, slot_start_d;
    logic [3:0]          digit;
    logic                blank;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    assign digit = snap_q[{idx_q, 2'b00} +: 4];

`ifdef BCD_SCAN_LZB_EN
    // A digit is blank when it and everything above it is zero; digit 0 always shows.
    logic [DIGITS-1:0] lzb;
    always_comb begin
        logic zeros;
        zeros = 1'b1;
        lzb   = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zeros  = zeros & (snap_q[4*i +: 4] == 4'd0);
            lzb[i] = zeros;
        end
    end
    assign blank = lzb[idx_q];
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        snap_d       = bus.load ? bus.bcd_in : snap_q;
        pre_d        = pre_q;
        idx_d        = idx_q;
        seg_d        = 7'h7F;
        an_d         = '1;
        slot_start_d = 1'b0;
        if (bus.en) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
            seg_d        = blank ? 7'h7F : decode(digit);
            slot_start_d = (pre_q == '0);
            // Anodes stay off for the first GUARD cycles of a slot to avoid ghosting.
            if (pre_q >= GUARD_P && !blank)
                an_d = ~(DIGITS'(1) << idx_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_q       <= '0;
            pre_q        <= '0;
            idx_q        <= '0;
            seg_q        <= 7'h7F;
            an_q         <= '1;
            slot_start_q <= 1'b0;
        end else begin
            snap_q       <= snap_d;
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            slot_start_q <= slot_start_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.slot_start = slot_start_q;
endmodule
